// File: rtl/i2s_tx_master_if.sv
// Sample handshake between the filter-bank output stage and the I2S transmitter.
// One stereo frame (left/right) is offered per valid/ready transfer.
interface i2s_tx_master_if #(
    parameter int DATA_W = 24
) ();
    logic [DATA_W-1:0] left_i;
    logic [DATA_W-1:0] right_i;
    logic              sample_valid_i;
    logic              sample_ready_o;

    modport master (
        output left_i,
        output right_i,
        output sample_valid_i,
        input  sample_ready_o
    );

    modport slave (
        input  left_i,
        input  right_i,
        input  sample_valid_i,
        output sample_ready_o
    );
endinterface

// File: rtl/i2s_tx_master.sv
// I2S master transmitter: SCK/WS generation and MSB-first stereo serializer.
// Define I2S_TX_MUTE_ON_UNDERRUN_EN to send silence instead of repeating the last frame on underrun.
module i2s_tx_master #(
    parameter int CLK_DIV = 4,
    parameter int DATA_W  = 24,
    parameter int SLOT_W  = 32
) (
    input  logic           lmmi_clk_i,
    input  logic           reset_i,
    input  logic           enable_i,
    i2s_tx_master_if.slave smp,
    output logic           i2s_sck_o,
    output logic           i2s_ws_o,
    output logic           i2s_sd_o,
    output logic           frame_start_o,
    output logic           underrun_o,
    output logic           busy_o
);
    localparam int FRAME = 2 * SLOT_W;
    localparam int BW    = $clog2(FRAME);
    localparam int CW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [BW-1:0] LAST  = BW'(FRAME - 1);
    localparam logic [BW-1:0] WS_LO = BW'(SLOT_W - 1);
    localparam logic [BW-1:0] WS_HI = BW'(FRAME - 2);
    localparam logic [BW-1:0] L_HI  = BW'(DATA_W - 1);
    localparam logic [BW-1:0] R_LO  = BW'(SLOT_W);
    localparam logic [BW-1:0] R_HI  = BW'(SLOT_W + DATA_W - 1);
    localparam logic [CW-1:0] DV_TC = CW'(CLK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_e;

    state_e            state_q, state_d;
    logic [CW-1:0]     div_q, div_d;
    logic [BW-1:0]     bit_q, bit_d;
    logic              sck_q, sck_d;
    logic              ws_q, ws_d;
    logic              sd_q, sd_d;
    logic              fs_q, fs_d;
    logic              ur_q, ur_d;
    logic              hold_full_q, hold_full_d;
    logic [DATA_W-1:0] hold_l_q, hold_l_d;
    logic [DATA_W-1:0] hold_r_q, hold_r_d;
    logic [DATA_W-1:0] last_l_q, last_l_d;
    logic [DATA_W-1:0] last_r_q, last_r_d;
    logic [DATA_W-1:0] cur_l_q, cur_l_d;
    logic [DATA_W-1:0] cur_r_q, cur_r_d;

    logic              tc;
    logic              fall;
    logic              accept;
    logic [BW-1:0]     bit_nxt;
    logic              run_clk;
    logic [DATA_W-1:0] lsh;
    logic [DATA_W-1:0] rsh;

    assign tc      = (div_q == DV_TC);
    assign fall    = tc && sck_q;
    assign accept  = smp.sample_valid_i && !hold_full_q;
    assign bit_nxt = (bit_q == LAST) ? '0 : bit_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        bit_d       = bit_q;
        sck_d       = sck_q;
        ws_d        = ws_q;
        sd_d        = sd_q;
        fs_d        = 1'b0;
        ur_d        = 1'b0;
        hold_full_d = hold_full_q;
        hold_l_d    = hold_l_q;
        hold_r_d    = hold_r_q;
        last_l_d    = last_l_q;
        last_r_d    = last_r_q;
        cur_l_d     = cur_l_q;
        cur_r_d     = cur_r_q;
        run_clk     = 1'b0;
        lsh         = '0;
        rsh         = '0;

        unique case (state_q)
            IDLE: begin
                sck_d = 1'b0;
                ws_d  = 1'b0;
                sd_d  = 1'b0;
                div_d = '0;
                bit_d = LAST;
                if (enable_i) state_d = RUN;
            end
            RUN: begin
                run_clk = 1'b1;
                if (!enable_i) state_d = DRAIN;
            end
            DRAIN: begin
                run_clk = 1'b1;
                if (enable_i) begin
                    state_d = RUN;
                end else if (fall && bit_q == LAST) begin
                    // Last bit of the frame has been held for a full SCK: stop here.
                    state_d = IDLE;
                    run_clk = 1'b0;
                    sck_d   = 1'b0;
                    ws_d    = 1'b0;
                    sd_d    = 1'b0;
                    div_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase

        if (run_clk) begin
            div_d = tc ? '0 : div_q + 1'b1;
            if (tc) sck_d = !sck_q;
            if (fall) begin
                bit_d = bit_nxt;
                if (bit_q == LAST) begin
                    fs_d = 1'b1;
                    if (hold_full_q) begin
                        cur_l_d     = hold_l_q;
                        cur_r_d     = hold_r_q;
                        last_l_d    = hold_l_q;
                        last_r_d    = hold_r_q;
                        hold_full_d = 1'b0;
                    end else begin
                        ur_d = 1'b1;
`ifdef I2S_TX_MUTE_ON_UNDERRUN_EN
                        cur_l_d = '0;
                        cur_r_d = '0;
`else
                        cur_l_d = last_l_q;
                        cur_r_d = last_r_q;
`endif
                    end
                end
                lsh  = cur_l_d << bit_nxt;
                rsh  = cur_r_d << (bit_nxt - R_LO);
                ws_d = (bit_nxt >= WS_LO) && (bit_nxt <= WS_HI);
                sd_d = 1'b0;
                if (bit_nxt <= L_HI) begin
                    sd_d = lsh[DATA_W-1];
                end else if (bit_nxt >= R_LO && bit_nxt <= R_HI) begin
                    sd_d = rsh[DATA_W-1];
                end
            end
        end

        // A frame taken on an empty-buffer boundary waits for the next frame.
        if (accept) begin
            hold_l_d    = smp.left_i;
            hold_r_d    = smp.right_i;
            hold_full_d = 1'b1;
        end
    end

    always_ff @(posedge lmmi_clk_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            div_q       <= '0;
            bit_q       <= LAST;
            sck_q       <= 1'b0;
            ws_q        <= 1'b0;
            sd_q        <= 1'b0;
            fs_q        <= 1'b0;
            ur_q        <= 1'b0;
            hold_full_q <= 1'b0;
            hold_l_q    <= '0;
            hold_r_q    <= '0;
            last_l_q    <= '0;
            last_r_q    <= '0;
            cur_l_q     <= '0;
            cur_r_q     <= '0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            bit_q       <= bit_d;
            sck_q       <= sck_d;
            ws_q        <= ws_d;
            sd_q        <= sd_d;
            fs_q        <= fs_d;
            ur_q        <= ur_d;
            hold_full_q <= hold_full_d;
            hold_l_q    <= hold_l_d;
            hold_r_q    <= hold_r_d;
            last_l_q    <= last_l_d;
            last_r_q    <= last_r_d;
            cur_l_q     <= cur_l_d;
            cur_r_q     <= cur_r_d;
        end
    end

    assign smp.sample_ready_o = !hold_full_q;
    assign i2s_sck_o          = sck_q;
    assign i2s_ws_o           = ws_q;
    assign i2s_sd_o           = sd_q;
    assign frame_start_o      = fs_q;
    assign underrun_o         = ur_q;
    assign busy_o             = (state_q != IDLE);
endmodule

// File: tb/tb_i2s_tx_master.sv
// Bench for i2s_tx_master: deserializes the I2S stream on SCK rising edges
// and checks it against a frame-queue model of the holding buffer.
`timescale 1ns/1ps
module tb_i2s_tx_master;
    localparam int CLK_DIV   = 2;
    localparam int DATA_W    = 24;
    localparam int SLOT_W    = 32;
    localparam int FBITS     = 2 * SLOT_W;
    localparam int FRAME_CLK = FBITS * 2 * CLK_DIV;
    localparam int BOUND     = 20000;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic en  = 1'b0;
    logic sck, ws, sd, fs, ur, busy;

    i2s_tx_master_if #(.DATA_W(DATA_W)) smp ();

    i2s_tx_master #(
        .CLK_DIV(CLK_DIV),
        .DATA_W (DATA_W),
        .SLOT_W (SLOT_W)
    ) dut (
        .lmmi_clk_i   (clk),
        .reset_i      (rst),
        .enable_i     (en),
        .smp          (smp),
        .i2s_sck_o    (sck),
        .i2s_ws_o     (ws),
        .i2s_sd_o     (sd),
        .frame_start_o(fs),
        .underrun_o   (ur),
        .busy_o       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DATA_W-1:0] l;
        logic [DATA_W-1:0] r;
        int                acc;
    } pend_t;

    typedef struct {
        logic [DATA_W-1:0] l;
        logic [DATA_W-1:0] r;
        logic              ok;
    } frm_t;

    pend_t pend_q[$];
    frm_t  exp_q[$];
    frm_t  rx_q[$];
    frm_t  last_rx;
    logic [DATA_W-1:0] last_l = '0;
    logic [DATA_W-1:0] last_r = '0;
    logic [FBITS-1:0]  sd_bits, ws_bits;
    int    cyc = 0;
    int    checks = 0, errors = 0;
    int    ur_err = 0, fs_err = 0, gap_err = 0, rdy_err = 0;
    int    fs_cnt = 0, ur_cnt = 0, rx_total = 0;
    int    pos = 0, prev_fs = -1, prev_rise = -1;
    bit    collecting = 0;
    logic  sck_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic frm_t decode(input logic [FBITS-1:0] s, input logic [FBITS-1:0] w);
        frm_t f;
        f.l  = '0;
        f.r  = '0;
        f.ok = 1'b1;
        for (int i = 0; i < FBITS; i++) begin
            if (w[i] !== ((i >= SLOT_W - 1) && (i <= FBITS - 2))) f.ok = 1'b0;
            if (i < DATA_W) f.l[DATA_W-1-i] = s[i];
            else if (i >= SLOT_W && i < SLOT_W + DATA_W) f.r[DATA_W-1-(i-SLOT_W)] = s[i];
            else if (s[i] !== 1'b0) f.ok = 1'b0;
        end
        return f;
    endfunction

    // Stream monitor and buffer model: one entry consumed per frame boundary.
    always @(negedge clk) begin
        frm_t  e;
        pend_t p;
        logic  exp_ur;
        if (rst) begin
            collecting = 0;
            pos        = 0;
            prev_fs    = -1;
            prev_rise  = -1;
            sck_prev   = 1'b0;
        end else begin
            if (!busy) begin
                prev_fs   = -1;
                prev_rise = -1;
            end
            if (sck && !sck_prev) begin
                if (prev_rise >= 0 && cyc - prev_rise != 2 * CLK_DIV) gap_err++;
                prev_rise = cyc;
                if (collecting) begin
                    sd_bits[pos] = sd;
                    ws_bits[pos] = ws;
                    pos++;
                    if (pos == FBITS) begin
                        rx_q.push_back(decode(sd_bits, ws_bits));
                        rx_total++;
                        collecting = 0;
                    end
                end
            end
            if (fs) begin
                fs_cnt++;
                if (prev_fs >= 0 && cyc - prev_fs != FRAME_CLK) fs_err++;
                prev_fs    = cyc;
                collecting = 1;
                pos        = 0;
                e.ok       = 1'b1;
                if (pend_q.size() > 0 && pend_q[0].acc < cyc) begin
                    p      = pend_q.pop_front();
                    e.l    = p.l;
                    e.r    = p.r;
                    last_l = p.l;
                    last_r = p.r;
                    exp_ur = 1'b0;
                    if (smp.sample_ready_o !== 1'b1) rdy_err++;
                end else begin
                    exp_ur = 1'b1;
`ifdef I2S_TX_MUTE_ON_UNDERRUN_EN
                    e.l = '0;
                    e.r = '0;
`else
                    e.l = last_l;
                    e.r = last_r;
`endif
                end
                exp_q.push_back(e);
                if (ur !== exp_ur) ur_err++;
            end else if (ur) begin
                ur_err++;
            end
            if (ur) ur_cnt++;
            sck_prev = sck;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic send(input logic [DATA_W-1:0] l, input logic [DATA_W-1:0] r);
        int n = 0;
        int acc;
        smp.left_i         = l;
        smp.right_i        = r;
        smp.sample_valid_i = 1'b1;
        while (smp.sample_ready_o !== 1'b1 && n < BOUND) begin
            tick();
            n++;
        end
        chk("send_wait", 32'(n < BOUND), 1);
        if (n < BOUND) begin
            acc = cyc + 1;
            tick();
            pend_q.push_back('{l, r, acc});
            chk("ready_fall", 32'(smp.sample_ready_o), 0);
        end
    endtask

    task automatic wait_fs(input int target);
        int n = 0;
        while (fs_cnt < target && n < BOUND) begin
            tick();
            n++;
        end
        chk("wait_fs", 32'(n < BOUND), 1);
    endtask

    task automatic wait_pos(input int k);
        int n = 0;
        while (!(collecting && pos == k) && n < BOUND) begin
            tick();
            n++;
        end
        chk("wait_pos", 32'(n < BOUND), 1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy !== 1'b0 && n < BOUND) begin
            tick();
            n++;
        end
        chk("wait_idle", 32'(n < BOUND), 1);
    endtask

    task automatic compare_frames();
        frm_t r, e;
        while (rx_q.size() > 0 && exp_q.size() > 0) begin
            r = rx_q.pop_front();
            e = exp_q.pop_front();
            chk("frame_left", 32'(r.l), 32'(e.l));
            chk("frame_right", 32'(r.r), 32'(e.r));
            chk("frame_ws_pad", 32'(r.ok), 1);
            last_rx = r;
        end
    endtask

    task automatic clear_model();
        pend_q.delete();
        exp_q.delete();
        rx_q.delete();
        last_l = '0;
        last_r = '0;
    endtask

    initial begin
        int bad;
        int fs0, ur0, rx0;
        logic [DATA_W-1:0] v;
        smp.left_i         = '0;
        smp.right_i        = '0;
        smp.sample_valid_i = 1'b0;

        // Reset and idle
        tick();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("rst_sck", 32'(sck), 0);
        chk("rst_ws", 32'(ws), 0);
        chk("rst_sd", 32'(sd), 0);
        chk("rst_fs", 32'(fs), 0);
        chk("rst_ur", 32'(ur), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_ready", 32'(smp.sample_ready_o), 1);
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            if (sck !== 1'b0 || ws !== 1'b0 || sd !== 1'b0 || busy !== 1'b0 ||
                smp.sample_ready_o !== 1'b1) bad++;
            tick();
        end
        chk("idle_hold", 32'(bad), 0);

        // Basic frame with preload, then two random frames
        send(24'h800001, 24'h7FFFFE);
        en = 1'b1;
        send(24'($urandom), 24'($urandom));
        send(24'($urandom), 24'($urandom));

        // Back-pressure: valid held high with incrementing data
        for (int k = 1; k <= 6; k++) send(24'(k), 24'(k));

        // Underrun after a final frame
        send(24'h123456, 24'h123456);
        smp.sample_valid_i = 1'b0;
        fs0 = fs_cnt;
        ur0 = ur_cnt;
        wait_fs(fs0 + 3);
        chk("underrun_cnt", 32'(ur_cnt - ur0), 2);
        compare_frames();
`ifdef I2S_TX_MUTE_ON_UNDERRUN_EN
        chk("underrun_data", 32'(last_rx.l), 0);
`else
        chk("underrun_data", 32'(last_rx.l), 32'h123456);
`endif
        chk("fs_spacing", 32'(fs_err), 0);

        // Stop mid-frame: frame completes, then idle
        wait_pos(10);
        en  = 1'b0;
        fs0 = fs_cnt;
        rx0 = rx_total;
        wait_idle();
        chk("stop_sck", 32'(sck), 0);
        chk("stop_no_fs", 32'(fs_cnt), 32'(fs0));
        chk("stop_frame_done", 32'(rx_total - rx0), 1);
        compare_frames();

        // Restart, then re-enable during drain
        v = 24'($urandom);
        send(v, ~v);
        smp.sample_valid_i = 1'b0;
        en = 1'b1;
        wait_pos(10);
        en  = 1'b0;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (busy !== 1'b1) bad++;
            tick();
        end
        en = 1'b1;
        chk("drain_busy", 32'(bad), 0);
        fs0 = fs_cnt;
        wait_fs(fs0 + 2);
        chk("sck_gap", 32'(gap_err), 0);
        chk("fs_spacing2", 32'(fs_err), 0);
        compare_frames();

        // Reset mid-frame with a sample pending
        wait_pos(40);
        send(24'($urandom), 24'($urandom));
        smp.sample_valid_i = 1'b0;
        rst = 1'b1;
        en  = 1'b0;
        tick();
        chk("mid_rst_sck", 32'(sck), 0);
        chk("mid_rst_ws", 32'(ws), 0);
        chk("mid_rst_sd", 32'(sd), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_ready", 32'(smp.sample_ready_o), 1);
        clear_model();
        rst = 1'b0;
        tick();
        en  = 1'b1;
        fs0 = fs_cnt;
        ur0 = ur_cnt;
        wait_fs(fs0 + 2);
        chk("post_rst_ur", 32'(ur_cnt - ur0), 2);
        compare_frames();
        chk("post_rst_zero", 32'(last_rx.l), 0);
        en = 1'b0;
        wait_idle();

        chk("ur_model", 32'(ur_err), 0);
        chk("ready_rise", 32'(rdy_err), 0);
        chk("sck_gap_end", 32'(gap_err), 0);
        chk("fs_spacing_end", 32'(fs_err), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
